// File: rtl/ibex_multdiv_arbiter.sv
// Round-robin arbiter sharing one ibex-style multiply/divide engine between NREQ requesters.
// Latches the winner's operation, holds it on the engine, and returns the result with a watchdog.
module ibex_multdiv_arbiter #(
  parameter int NREQ       = 2,
  parameter int MAX_CYCLES = 40
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NREQ-1:0]   req_valid_i,
  output logic [NREQ-1:0]   req_ready_o,
  input  logic [2*NREQ-1:0] req_operator_i,
  input  logic [2*NREQ-1:0] req_signed_i,
  input  logic [32*NREQ-1:0] req_op_a_i,
  input  logic [32*NREQ-1:0] req_op_b_i,
  output logic [NREQ-1:0]   rsp_valid_o,
  input  logic [NREQ-1:0]   rsp_ready_i,
  output logic [31:0]       rsp_result_o,
  output logic              rsp_err_o,
  output logic              md_mult_en_o,
  output logic              md_div_en_o,
  output logic [1:0]        md_operator_o,
  output logic [1:0]        md_signed_mode_o,
  output logic [31:0]       md_op_a_o,
  output logic [31:0]       md_op_b_o,
  output logic              md_ready_o,
  input  logic              md_valid_i,
  input  logic [31:0]       md_result_i
);

  localparam int PW = (NREQ > 2) ? 2 : 1;
  localparam int WW = $clog2(MAX_CYCLES);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]    state;
  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] owner;
  logic [WW-1:0] wdog;
  logic [1:0]    operator_q;
  logic [1:0]    signed_q;
  logic [31:0]   op_a_q;
  logic [31:0]   op_b_q;
  logic [31:0]   result_q;
  logic          err_q;

  logic          grant_any;
  logic          found;
  logic [PW-1:0] grant;
  logic [1:0]    sel_operator;
  logic [1:0]    sel_signed;
  logic [31:0]   sel_op_a;
  logic [31:0]   sel_op_b;
  logic          owner_ready;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    grant_any    = |req_valid_i;
    found        = 1'b0;
    grant        = '0;
    sel_operator = '0;
    sel_signed   = '0;
    sel_op_a     = '0;
    sel_op_b     = '0;
    // Cyclic search: first pass covers rr_ptr..NREQ-1, second pass wraps to 0.
    for (int k = 0; k < NREQ; k++) begin
      if (!found && req_valid_i[k] && (PW'(k) >= rr_ptr)) begin
        found = 1'b1;
        grant = PW'(k);
      end
    end
    for (int k = 0; k < NREQ; k++) begin
      if (!found && req_valid_i[k]) begin
        found = 1'b1;
        grant = PW'(k);
      end
    end
    for (int k = 0; k < NREQ; k++) begin
      if (grant == PW'(k)) begin
        sel_operator = req_operator_i[2*k +: 2];
        sel_signed   = req_signed_i[2*k +: 2];
        sel_op_a     = req_op_a_i[32*k +: 32];
        sel_op_b     = req_op_b_i[32*k +: 32];
      end
    end
  end

  always_comb begin
    req_ready_o = '0;
    rsp_valid_o = '0;
    owner_ready = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      // Gated by reset too, so the port reads 0 while reset is held.
      req_ready_o[k] = (state == S_IDLE) && grant_any && !rst_i && (grant == PW'(k));
      rsp_valid_o[k] = (state == S_RESP) && (owner == PW'(k));
      if (owner == PW'(k)) owner_ready = rsp_ready_i[k];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= S_IDLE;
      rr_ptr     <= '0;
      owner      <= '0;
      wdog       <= '0;
      operator_q <= '0;
      signed_q   <= '0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      result_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant_any) begin
            owner      <= grant;
            operator_q <= sel_operator;
            signed_q   <= sel_signed;
            op_a_q     <= sel_op_a;
            op_b_q     <= sel_op_b;
            wdog       <= '0;
            state      <= S_BUSY;
          end
        end
        S_BUSY: begin
          wdog <= wdog + 1'b1;
          if (md_valid_i) begin
            result_q <= md_result_i;
            err_q    <= 1'b0;
            state    <= S_RESP;
          end else if (wdog == WW'(MAX_CYCLES - 1)) begin
            result_q <= '0;
            err_q    <= 1'b1;
            state    <= S_RESP;
          end
        end
        S_RESP: begin
          if (owner_ready) begin
            rr_ptr <= (owner == PW'(NREQ - 1)) ? '0 : owner + 1'b1;
            state  <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Enables decode from state so they fall in the same cycle the engine must stop.
  assign md_ready_o       = (state == S_BUSY);
  assign md_mult_en_o     = (state == S_BUSY) && !operator_q[1];
  assign md_div_en_o      = (state == S_BUSY) && operator_q[1];
  assign md_operator_o    = operator_q;
  assign md_signed_mode_o = signed_q;
  assign md_op_a_o        = op_a_q;
  assign md_op_b_o        = op_b_q;
  assign rsp_result_o     = (state == S_RESP) ? result_q : '0;
  assign rsp_err_o        = (state == S_RESP) && err_q;

endmodule

// File: tb/tb_ibex_multdiv_arbiter.sv
// Self-checking bench for ibex_multdiv_arbiter: behavioural engine, round-robin order model,
// directed scenarios followed by randomized traffic.
module tb_ibex_multdiv_arbiter;

  localparam int NREQ       = 3;
  localparam int MAX_CYCLES = 40;

  logic                 clk;
  logic                 rst_i;
  logic [NREQ-1:0]      req_valid_i;
  logic [NREQ-1:0]      req_ready_o;
  logic [2*NREQ-1:0]    req_operator_i;
  logic [2*NREQ-1:0]    req_signed_i;
  logic [32*NREQ-1:0]   req_op_a_i;
  logic [32*NREQ-1:0]   req_op_b_i;
  logic [NREQ-1:0]      rsp_valid_o;
  logic [NREQ-1:0]      rsp_ready_i;
  logic [31:0]          rsp_result_o;
  logic                 rsp_err_o;
  logic                 md_mult_en_o;
  logic                 md_div_en_o;
  logic [1:0]           md_operator_o;
  logic [1:0]           md_signed_mode_o;
  logic [31:0]          md_op_a_o;
  logic [31:0]          md_op_b_o;
  logic                 md_ready_o;
  logic                 md_valid_i;
  logic [31:0]          md_result_i;

  ibex_multdiv_arbiter #(.NREQ(NREQ), .MAX_CYCLES(MAX_CYCLES)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_operator_i(req_operator_i), .req_signed_i(req_signed_i),
    .req_op_a_i(req_op_a_i), .req_op_b_i(req_op_b_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_result_o(rsp_result_o), .rsp_err_o(rsp_err_o),
    .md_mult_en_o(md_mult_en_o), .md_div_en_o(md_div_en_o),
    .md_operator_o(md_operator_o), .md_signed_mode_o(md_signed_mode_o),
    .md_op_a_o(md_op_a_o), .md_op_b_o(md_op_b_o), .md_ready_o(md_ready_o),
    .md_valid_i(md_valid_i), .md_result_i(md_result_i)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int          owner;
    logic [31:0] res;
    logic        err;
    int          busy;
  } rsp_t;

  int checks = 0;
  int errors = 0;

  logic [NREQ-1:0] pend;
  logic [1:0]  t_opc [NREQ];
  logic [1:0]  t_sm  [NREQ];
  logic [31:0] t_a   [NREQ];
  logic [31:0] t_b   [NREQ];
  logic [31:0] t_exp [NREQ];

  rsp_t rq[$];
  int   grant_q[$];
  int   eng_lat_q[$];
  int   eo[$];
  int   m_rr;
  bit   eng_hang;
  int   eng_viol;
  int   eng_cnt;
  int   eng_lat;
  logic [67:0] eng_snap;

  // Mathematical meaning of each opcode; x/0 and signed overflow follow the ibex conventions.
  function automatic logic [31:0] ref_result(input logic [1:0] opc, input logic [1:0] sm,
                                             input logic [31:0] a, input logic [31:0] b);
    logic [63:0] xa, xb, p;
    logic        sgn, ovf;
    xa  = sm[0] ? {{32{a[31]}}, a} : {32'b0, a};
    xb  = sm[1] ? {{32{b[31]}}, b} : {32'b0, b};
    p   = xa * xb;
    sgn = sm[0] & sm[1];
    ovf = sgn && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (opc)
      2'd0: return p[31:0];
      2'd1: return p[63:32];
      2'd2: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (ovf)        return 32'h8000_0000;
        if (sgn)        return $signed(a) / $signed(b);
        return a / b;
      end
      default: begin
        if (b == 32'd0) return a;
        if (ovf)        return 32'd0;
        if (sgn)        return $signed(a) % $signed(b);
        return a % b;
      end
    endcase
  endfunction

  function automatic int oh_idx(input logic [NREQ-1:0] v);
    int idx;
    idx = -1;
    for (int k = NREQ - 1; k >= 0; k--) if (v[k]) idx = k;
    return idx;
  endfunction

  function automatic rsp_t next_rsp();
    rsp_t r;
    r = '{owner: -1, res: 32'h0, err: 1'b0, busy: -1};
    if (rq.size() != 0) r = rq.pop_front();
    return r;
  endfunction

  // Engine model: finishes after a random latency unless hung; flags unstable operands.
  initial begin
    md_valid_i = 1'b0;
    md_result_i = '0;
    eng_cnt = 0;
    eng_viol = 0;
    forever begin
      @(posedge clk);
      #1;
      if (rst_i || !(md_mult_en_o || md_div_en_o)) begin
        eng_cnt = 0;
        md_valid_i = 1'b0;
        md_result_i = '0;
      end else begin
        if (eng_cnt == 0) begin
          eng_lat  = $urandom_range(1, 37);
          eng_snap = {md_operator_o, md_signed_mode_o, md_op_a_o, md_op_b_o};
        end else if (eng_snap !== {md_operator_o, md_signed_mode_o, md_op_a_o, md_op_b_o}) begin
          eng_viol++;
        end
        if (md_mult_en_o !== (md_operator_o < 2'd2) || md_div_en_o !== (md_operator_o >= 2'd2))
          eng_viol++;
        eng_cnt++;
        if (!eng_hang && eng_cnt == eng_lat) begin
          md_valid_i  = 1'b1;
          md_result_i = ref_result(md_operator_o, md_signed_mode_o, md_op_a_o, md_op_b_o);
          eng_lat_q.push_back(eng_lat);
        end else begin
          md_valid_i = 1'b0;
        end
      end
    end
  end

  task automatic post(input int k, input logic [1:0] opc, input logic [1:0] sm,
                      input logic [31:0] a, input logic [31:0] b);
    t_opc[k] = opc;
    t_sm[k]  = sm;
    t_a[k]   = a;
    t_b[k]   = b;
    t_exp[k] = ref_result(opc, sm, a, b);
    pend[k]  = 1'b1;
  endtask

  // Idle requesters carry random junk so operand capture is only correct if sampled at the grant.
  task automatic drive();
    for (int k = 0; k < NREQ; k++) begin
      req_valid_i[k] = pend[k];
      req_operator_i[2*k +: 2] = pend[k] ? t_opc[k] : 2'($urandom);
      req_signed_i[2*k +: 2]   = pend[k] ? t_sm[k]  : 2'($urandom);
      req_op_a_i[32*k +: 32]   = pend[k] ? t_a[k]   : $urandom;
      req_op_b_i[32*k +: 32]   = pend[k] ? t_b[k]   : $urandom;
    end
    rsp_ready_i = '0;
  endtask

  task automatic serve(input int n_ops, input int hold, output int viol);
    int done, cyc, hcnt, busy, g;
    done = 0; cyc = 0; hcnt = 0; busy = 0; viol = 0;
    while (done < n_ops && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      drive();
      #1;
      if (md_ready_o) busy++;
      if ($countones(rsp_valid_o) > 1 || $countones(req_ready_o) > 1) viol++;
      if (rsp_valid_o != '0) begin
        if (hcnt < hold) hcnt++;
        else begin
          rsp_ready_i = rsp_valid_o;
          rq.push_back('{owner: oh_idx(rsp_valid_o), res: rsp_result_o, err: rsp_err_o, busy: busy});
          busy = 0;
          hcnt = 0;
          done++;
        end
      end
      if (req_ready_o != '0) begin
        g = oh_idx(req_ready_o);
        if (!pend[g]) viol++;
        grant_q.push_back(g);
        pend[g] = 1'b0;
      end
    end
    if (done < n_ops) begin
      checks++; errors++;
      $display("FAIL serve_timeout responses=%0d required=%0d", done, n_ops);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_i = 1'b1;
    pend = '0;
    req_valid_i = '0;
    rsp_ready_i = '0;
    repeat (2) @(negedge clk);
    rst_i = 1'b0;
    m_rr = 0;
  endtask

  task automatic clear_logs();
    rq.delete();
    grant_q.delete();
    eng_lat_q.delete();
    eo.delete();
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({req_ready_o, rsp_valid_o, rsp_result_o, rsp_err_o, md_mult_en_o, md_div_en_o, md_operator_o,
         md_signed_mode_o, md_op_a_o, md_op_b_o, md_ready_o} !== '0) begin
      errors++;
      $display("FAIL reset_outputs ready=%b rsp_valid=%b md_ready=%b required all zero",
               req_ready_o, rsp_valid_o, md_ready_o);
    end
    @(negedge clk);
    rst_i = 1'b0;
    req_valid_i = '0;
    m_rr = 0;
  endtask

  task automatic test_single();
    int viol, lat;
    rsp_t r;
    clear_logs();
    post(0, 2'd0, 2'd0, 32'd7, 32'd6);
    serve(1, 0, viol);
    r = next_rsp();
    lat = (eng_lat_q.size() != 0) ? eng_lat_q[0] : -2;
    checks++;
    if ({r.owner, r.res, r.err} !== {32'sd0, 32'd42, 1'b0}) begin
      errors++;
      $display("FAIL single_mull owner=%0d result=%0d err=%b required 0/42/0", r.owner, r.res, r.err);
    end
    checks++;
    if (grant_q.size() != 1 || grant_q[0] != 0) begin
      errors++;
      $display("FAIL single_grant pulses=%0d required one pulse on req0", grant_q.size());
    end
    checks++;
    if (r.busy !== lat) begin
      errors++;
      $display("FAIL single_latency busy_cycles=%0d required %0d", r.busy, lat);
    end
    m_rr = 1;
  endtask

  task automatic test_rr();
    int viol, vsum;
    rsp_t r;
    int          exp_own [5] = '{0, 1, 0, 1, 0};
    logic [31:0] exp_res [5] = '{32'hFFFF_FFFF, 32'd14, 32'd4, 32'd14, 32'hFFFF_FFFF};
    clear_logs();
    vsum = 0;
    post(0, 2'd1, 2'b11, 32'h8000_0000, 32'd2);
    post(1, 2'd2, 2'b00, 32'd100, 32'd7);
    serve(2, 0, viol); vsum += viol;
    post(0, 2'd0, 2'b00, 32'd2, 32'd2);
    serve(1, 0, viol); vsum += viol;
    post(0, 2'd1, 2'b11, 32'h8000_0000, 32'd2);
    post(1, 2'd2, 2'b00, 32'd100, 32'd7);
    serve(2, 0, viol); vsum += viol;
    for (int i = 0; i < 5; i++) begin
      r = next_rsp();
      checks++;
      if ({r.owner, r.res, r.err} !== {exp_own[i], exp_res[i], 1'b0}) begin
        errors++;
        $display("FAIL rr_order[%0d] owner=%0d result=%h err=%b required %0d/%h/0",
                 i, r.owner, r.res, r.err, exp_own[i], exp_res[i]);
      end
    end
    checks++;
    if (vsum != 0) begin
      errors++;
      $display("FAIL rr_protocol violations=%0d required 0", vsum);
    end
  endtask

  task automatic test_div_zero();
    int viol;
    rsp_t r;
    clear_logs();
    post(1, 2'd3, 2'b00, 32'd100, 32'd0);
    serve(1, 0, viol);
    post(0, 2'd2, 2'b00, 32'd5, 32'd0);
    serve(1, 0, viol);
    r = next_rsp();
    checks++;
    if ({r.owner, r.res, r.err} !== {32'sd1, 32'd100, 1'b0}) begin
      errors++;
      $display("FAIL rem_by_zero owner=%0d result=%h err=%b required 1/64/0", r.owner, r.res, r.err);
    end
    r = next_rsp();
    checks++;
    if ({r.owner, r.res, r.err} !== {32'sd0, 32'hFFFF_FFFF, 1'b0}) begin
      errors++;
      $display("FAIL div_by_zero owner=%0d result=%h err=%b required 0/ffffffff/0", r.owner, r.res, r.err);
    end
  endtask

  // Pointer is 1 here, so req1 wins; its response is held while req0 and the other bits wait.
  task automatic test_hold();
    int viol, cyc;
    logic [NREQ-1:0] v0;
    logic [31:0] r0;
    rsp_t r;
    clear_logs();
    post(0, 2'd0, 2'b00, 32'd3, 32'd5);
    post(1, 2'd0, 2'b00, 32'd4, 32'd5);
    cyc = 0;
    do begin
      @(negedge clk);
      drive();
      #1;
      if (req_ready_o != '0) pend[oh_idx(req_ready_o)] = 1'b0;
      cyc++;
    end while (rsp_valid_o == '0 && cyc < 200);
    v0 = rsp_valid_o;
    r0 = rsp_result_o;
    checks++;
    if ({v0, r0} !== {NREQ'(2), 32'd20}) begin
      errors++;
      $display("FAIL hold_first rsp_valid=%b result=%0d required %b/20", v0, r0, NREQ'(2));
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      drive();
      rsp_ready_i = ~v0;
      #1;
      checks++;
      if (rsp_valid_o !== v0 || rsp_result_o !== r0 || req_ready_o !== '0 ||
          md_mult_en_o !== 1'b0 || md_div_en_o !== 1'b0) begin
        errors++;
        $display("FAIL hold_stable[%0d] rsp_valid=%b result=%0d ready=%b en=%b%b required %b/%0d/0/00",
                 c, rsp_valid_o, rsp_result_o, req_ready_o, md_mult_en_o, md_div_en_o, v0, r0);
      end
    end
    serve(2, 0, viol);
    r = next_rsp();
    checks++;
    if ({r.owner, r.res} !== {32'sd1, 32'd20}) begin
      errors++;
      $display("FAIL hold_release owner=%0d result=%0d required 1/20", r.owner, r.res);
    end
    r = next_rsp();
    checks++;
    if ({r.owner, r.res, viol} !== {32'sd0, 32'd15, 32'sd0}) begin
      errors++;
      $display("FAIL hold_next owner=%0d result=%0d viol=%0d required 0/15/0", r.owner, r.res, viol);
    end
  endtask

  task automatic test_watchdog();
    int viol;
    rsp_t r;
    clear_logs();
    eng_hang = 1'b1;
    post(0, 2'd2, 2'b00, 32'd9, 32'd3);
    serve(1, 0, viol);
    eng_hang = 1'b0;
    r = next_rsp();
    checks++;
    if ({r.owner, r.res, r.err} !== {32'sd0, 32'd0, 1'b1}) begin
      errors++;
      $display("FAIL watchdog_rsp owner=%0d result=%h err=%b required 0/0/1", r.owner, r.res, r.err);
    end
    checks++;
    if (r.busy != MAX_CYCLES) begin
      errors++;
      $display("FAIL watchdog_cycles busy_cycles=%0d required %0d", r.busy, MAX_CYCLES);
    end
  endtask

  // Pointer is 1 here; if reset failed to clear it, req1 would win the post-reset race.
  task automatic test_reset_mid();
    int viol, cyc;
    rsp_t r;
    clear_logs();
    eng_hang = 1'b1;
    post(1, 2'd0, 2'b00, 32'd5, 32'd5);
    cyc = 0;
    do begin
      @(negedge clk);
      drive();
      #1;
      cyc++;
    end while (req_ready_o == '0 && cyc < 20);
    pend = '0;
    repeat (10) begin
      @(negedge clk);
      drive();
    end
    #1;
    checks++;
    if (md_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL midreset_busy md_ready=%b required 1", md_ready_o);
    end
    @(negedge clk);
    rst_i = 1'b1;
    req_valid_i = '1;
    #1;
    checks++;
    if ({req_ready_o, rsp_valid_o, rsp_result_o, rsp_err_o, md_mult_en_o, md_div_en_o, md_operator_o,
         md_signed_mode_o, md_op_a_o, md_op_b_o, md_ready_o} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs en=%b%b md_ready=%b op_a=%h ready=%b required all zero",
               md_mult_en_o, md_div_en_o, md_ready_o, md_op_a_o, req_ready_o);
    end
    repeat (2) @(negedge clk);
    rst_i = 1'b0;
    eng_hang = 1'b0;
    req_valid_i = '0;
    post(0, 2'd0, 2'b00, 32'd3, 32'd3);
    post(1, 2'd2, 2'b00, 32'd9, 32'd3);
    serve(2, 0, viol);
    checks++;
    if (rq.size() != 2) begin
      errors++;
      $display("FAIL midreset_count responses=%0d required 2", rq.size());
    end
    r = next_rsp();
    checks++;
    if ({r.owner, r.res, r.err} !== {32'sd0, 32'd9, 1'b0}) begin
      errors++;
      $display("FAIL midreset_first owner=%0d result=%0d err=%b required 0/9/0", r.owner, r.res, r.err);
    end
    r = next_rsp();
    checks++;
    if ({r.owner, r.res, r.err} !== {32'sd1, 32'd3, 1'b0}) begin
      errors++;
      $display("FAIL midreset_second owner=%0d result=%0d err=%b required 1/3/0", r.owner, r.res, r.err);
    end
  endtask

  task automatic test_random();
    int viol, hold, lat, k;
    logic [NREQ-1:0] mask;
    rsp_t r;
    do_reset();
    for (int it = 0; it < 25; it++) begin
      clear_logs();
      mask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      for (int j = 0; j < NREQ; j++)
        if (mask[j]) post(j, 2'($urandom), 2'($urandom), $urandom,
                          ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom);
      // Everyone pending is served once, visiting requesters cyclically from the pointer.
      for (int i = 0; i < NREQ; i++) begin
        k = (m_rr + i) % NREQ;
        if (mask[k]) eo.push_back(k);
      end
      m_rr = (eo[eo.size() - 1] + 1) % NREQ;
      hold = $urandom_range(0, 2);
      serve(eo.size(), hold, viol);
      foreach (eo[i]) begin
        r = next_rsp();
        lat = (eng_lat_q.size() != 0) ? eng_lat_q.pop_front() : -2;
        checks++;
        if ({r.owner, r.res, r.err} !== {eo[i], t_exp[eo[i]], 1'b0}) begin
          errors++;
          $display("FAIL rand[%0d.%0d] owner=%0d result=%h err=%b required %0d/%h/0",
                   it, i, r.owner, r.res, r.err, eo[i], t_exp[eo[i]]);
        end
        checks++;
        if (r.busy !== lat) begin
          errors++;
          $display("FAIL rand_latency[%0d.%0d] busy_cycles=%0d required %0d", it, i, r.busy, lat);
        end
      end
      checks++;
      if (viol != 0) begin
        errors++;
        $display("FAIL rand_protocol[%0d] violations=%0d required 0", it, viol);
      end
    end
    checks++;
    if (eng_viol != 0) begin
      errors++;
      $display("FAIL engine_interface violations=%0d required 0", eng_viol);
    end
  endtask

  initial begin
    rst_i          = 1'b1;
    req_valid_i    = '1;
    req_operator_i = '0;
    req_signed_i   = '0;
    req_op_a_i     = '0;
    req_op_b_i     = '0;
    rsp_ready_i    = '0;
    pend           = '0;
    eng_hang       = 1'b0;
    m_rr           = 0;
    test_reset();
    test_single();
    do_reset();
    test_rr();
    test_div_zero();
    test_hold();
    test_watchdog();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
